// File: rtl/style_flag_applier.sv
// style_flag_applier: buffers property-apply requests for one element in a
// small FIFO, validates each one in a decode stage, then writes the resolved
// value into its field of the noninherited-flags word. Tracks applied and
// rejected counts and pulses done when a finished element has fully drained.
module style_flag_applier #(
  parameter int                 FLAG_W      = 59,
  parameter int                 NPROP       = 4,
  parameter int                 VAL_W       = 5,
  parameter int                 FIFO_DEPTH  = 4,
  parameter logic [VAL_W-1:0]   INITIAL_VAL = 5'd1,
  parameter logic [VAL_W-1:0]   MAX_VAL     = 5'd20,
  localparam int                PW          = (NPROP > 1) ? $clog2(NPROP) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_base,
  input  logic [FLAG_W-1:0] base_flags,
  input  logic [FLAG_W-1:0] parent_flags,
  input  logic              end_elem,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [PW-1:0]     req_prop,
  input  logic [1:0]        req_mode,
  input  logic [5:0]        req_class,
  input  logic [VAL_W-1:0]  req_value,
  input  logic              element_valid,
  input  logic [31:0]       node_flag,
  output logic [FLAG_W-1:0] out_flags,
  output logic              busy,
  output logic              done,
  output logic [7:0]        applied_cnt,
  output logic [7:0]        rejected_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MODE_VALUE   = 2'd0,
    MODE_INITIAL = 2'd1,
    MODE_INHERIT = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  typedef struct packed {
    logic [PW-1:0]    prop;
    logic [1:0]       mode;
    logic [5:0]       cls;
    logic [VAL_W-1:0] value;
  } req_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  req_t              mem_q [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;

  logic              s1_valid_q, s1_valid_d;
  logic              s1_ok_q, s1_ok_d;
  logic [PW-1:0]     s1_prop_q, s1_prop_d;
  logic [1:0]        s1_mode_q, s1_mode_d;
  logic [VAL_W-1:0]  s1_value_q, s1_value_d;

  logic [FLAG_W-1:0] out_flags_q, out_flags_d;
  logic [7:0]        applied_q, applied_d;
  logic [7:0]        rejected_q, rejected_d;

  // ---------------------------------------------------------------------------
  // FIFO status and handshake
  // ---------------------------------------------------------------------------
  logic fifo_empty, fifo_full, push, pop;
  req_t head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head       = mem_q[rd_ptr_q[AW-1:0]];

  // A new element flushes everything, so nothing enters or leaves the FIFO
  // in the cycle load_base is seen.
  assign push = req_valid && req_ready && !load_base;
  assign pop  = !fifo_empty && !load_base;

  // Advance the FIFO pointers; they carry one extra wrap bit for full/empty.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first, so no path through the block can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (load_base) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Request storage; only the slot at the write pointer changes on a push.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; the pointers alone
    // decide which entries are live, and unreset RAM maps onto cheaper cells.
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= '{prop: req_prop, mode: req_mode,
                                   cls: req_class, value: req_value};
    end
  end

  // ---------------------------------------------------------------------------
  // Decode stage: validate the FIFO head as it is popped
  // ---------------------------------------------------------------------------
  logic [5:0] style_type;
  logic       head_ok;

  assign style_type = out_flags_q[41:36];

  // Legality of the head request against the element context of this cycle.
  always_comb begin
    head_ok = 1'b1;
    if ({{(32-PW){1'b0}}, head.prop} >= 32'(NPROP)) head_ok = 1'b0;
    if (head.mode == MODE_RSVD)                    head_ok = 1'b0;
    if (head.mode == MODE_VALUE) begin
      if (head.cls != 6'd0)        head_ok = 1'b0;
      if (head.value > MAX_VAL)    head_ok = 1'b0;
      // SVG elements with no style type only take the first three display values.
      if (head.prop == '0 && element_valid && node_flag[5] &&
          style_type == 6'd0 && head.value > VAL_W'(2)) begin
        head_ok = 1'b0;
      end
    end
  end

  // Load the decode register from the popped entry.
  always_comb begin
    s1_valid_d = 1'b0;
    s1_ok_d    = s1_ok_q;
    s1_prop_d  = s1_prop_q;
    s1_mode_d  = s1_mode_q;
    s1_value_d = s1_value_q;
    if (pop) begin
      s1_valid_d = 1'b1;
      s1_ok_d    = head_ok;
      s1_prop_d  = head.prop;
      s1_mode_d  = head.mode;
      s1_value_d = head.value;
    end
  end

  // ---------------------------------------------------------------------------
  // Write stage: resolve the value and update flags and counters
  // ---------------------------------------------------------------------------
  int unsigned      fld_lo;
  logic [VAL_W-1:0] wr_val;

  // Pick the value to write and place it in the selected field.
  always_comb begin
    fld_lo      = 32'(s1_prop_q) * 32'(VAL_W);
    wr_val      = s1_value_q;
    out_flags_d = out_flags_q;
    applied_d   = applied_q;
    rejected_d  = rejected_q;
    case (s1_mode_q)
      MODE_INITIAL: wr_val = INITIAL_VAL;
      MODE_INHERIT: wr_val = parent_flags[fld_lo +: VAL_W];
      default:      wr_val = s1_value_q;
    endcase
    if (load_base) begin
      out_flags_d = base_flags;
      applied_d   = 8'd0;
      rejected_d  = 8'd0;
    end else if (s1_valid_q) begin
      if (s1_ok_q) begin
        out_flags_d[fld_lo +: VAL_W] = wr_val;
        if (applied_q != 8'hFF) applied_d = applied_q + 8'd1;
      end else begin
        if (rejected_q != 8'hFF) rejected_d = rejected_q + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  logic pipe_empty;
  assign pipe_empty = fifo_empty && !s1_valid_q;

  // Next state and state-derived outputs.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    busy      = (state_q != IDLE);
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_base) state_d = RUN;
      end
      RUN: begin
        req_ready = !fifo_full;
        if (load_base)     state_d = RUN;
        else if (end_elem) state_d = DRAIN;
      end
      DRAIN: begin
        if (pipe_empty) done = 1'b1;
        if (load_base)       state_d = RUN;
        else if (pipe_empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_ok_q     <= 1'b0;
      s1_prop_q   <= '0;
      s1_mode_q   <= '0;
      s1_value_q  <= '0;
      out_flags_q <= '0;
      applied_q   <= 8'd0;
      rejected_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      s1_valid_q  <= s1_valid_d;
      s1_ok_q     <= s1_ok_d;
      s1_prop_q   <= s1_prop_d;
      s1_mode_q   <= s1_mode_d;
      s1_value_q  <= s1_value_d;
      out_flags_q <= out_flags_d;
      applied_q   <= applied_d;
      rejected_q  <= rejected_d;
    end
  end

  assign out_flags    = out_flags_q;
  assign applied_cnt  = applied_q;
  assign rejected_cnt = rejected_q;

endmodule
